// File: rtl/vjtag_trig_pkg.sv
// Shared op codes and mode encodings for the virtual-JTAG trigger bank.
package vjtag_trig_pkg;

  localparam logic [1:0] OP_BYPASS = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_STATUS = 2'b10;
  localparam logic [1:0] OP_MODE   = 2'b11;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_PULSE = 1'b1
  } trig_mode_e;

endpackage

// File: rtl/vjtag_trig_chan.sv
// One trigger channel: programmed value, level/pulse mode, pulse counter, commit strobe.
module vjtag_trig_chan
  import vjtag_trig_pkg::*;
#(
  parameter int TRIG_WIDTH = 32,
  parameter int PULSE_LEN  = 8
) (
  input  logic                  tck,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  mode_en,
  input  logic                  mode_bit,
  input  logic [TRIG_WIDTH-1:0] wr_data,
  output logic [TRIG_WIDTH-1:0] value,
  output logic                  mode,
  output logic [TRIG_WIDTH-1:0] trig_out,
  output logic                  trig_strobe
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  trig_mode_e       mode_q;

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      mode_q      <= MODE_LEVEL;
      cnt         <= '0;
      trig_strobe <= 1'b0;
    end else begin
      trig_strobe <= wr_en;
      if (wr_en) value <= wr_data;
      if (mode_en) mode_q <= trig_mode_e'(mode_bit);
      // A write reload beats expiry; entering pulse mode starts with the output quiet.
      if (wr_en && mode_q == MODE_PULSE) cnt <= CNT_LOAD;
      else if (mode_en && mode_q == MODE_LEVEL && mode_bit) cnt <= '0;
      else if (cnt != '0) cnt <= cnt - CNT_ONE;
    end
  end

  assign mode     = (mode_q == MODE_PULSE);
  assign trig_out = (mode_q == MODE_LEVEL || cnt != '0) ? value : '0;

endmodule

// File: rtl/vjtag_trig_bank.sv
// TCK-domain trigger register bank: op/channel decode, shared DR shift register, TDO mux.
module vjtag_trig_bank
  import vjtag_trig_pkg::*;
#(
  parameter int TRIG_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_BITS    = 2,
  parameter int PULSE_LEN  = 8,
  parameter int IR_WIDTH   = CH_BITS + 2
) (
  input  logic                         tck,
  input  logic                         rst_n,
  input  logic [IR_WIDTH-1:0]          ir_in,
  input  logic                         tdi,
  output logic                         tdo,
  input  logic                         cdr,
  input  logic                         sdr,
  input  logic                         udr,
  input  logic [NUM_CH*TRIG_WIDTH-1:0] status_in,
  output logic [NUM_CH*TRIG_WIDTH-1:0] trig_out,
  output logic [NUM_CH-1:0]            trig_strobe
);

  localparam logic [CH_BITS:0] NUM_CH_L = (CH_BITS + 1)'(NUM_CH);

  logic [1:0]            op;
  logic [CH_BITS-1:0]    ch;
  logic                  ch_ok;
  logic [1:0]            eff_op;
  logic                  shift_en;
  logic                  udr_en;
  logic [TRIG_WIDTH-1:0] sr;
  logic                  bypass_reg;
  logic [TRIG_WIDTH-1:0] sel_value;
  logic [TRIG_WIDTH-1:0] sel_status;
  logic                  sel_mode;
  logic [TRIG_WIDTH-1:0] ch_value [NUM_CH];
  logic [NUM_CH-1:0]     ch_mode;
  logic [NUM_CH-1:0]     wr_en;
  logic [NUM_CH-1:0]     mode_en;

  assign op     = ir_in[IR_WIDTH-1 -: 2];
  assign ch     = ir_in[CH_BITS-1:0];
  assign ch_ok  = {1'b0, ch} < NUM_CH_L;
  assign eff_op = ch_ok ? op : OP_BYPASS;

  // Capture beats shift beats update when the strobes overlap.
  assign shift_en = sdr && !cdr;
  assign udr_en   = udr && !cdr && !sdr;

  always_comb begin
    sel_value  = '0;
    sel_status = '0;
    sel_mode   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == CH_BITS'(k)) begin
        sel_value  = ch_value[k];
        sel_status = status_in[k*TRIG_WIDTH +: TRIG_WIDTH];
        sel_mode   = ch_mode[k];
      end
    end
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      bypass_reg <= 1'b0;
    end else begin
      bypass_reg <= tdi;
      if (cdr) begin
        case (eff_op)
          OP_WRITE:  sr <= sel_value;
          OP_STATUS: sr <= sel_status;
          OP_MODE:   sr <= {{(TRIG_WIDTH-1){1'b0}}, sel_mode};
          default:   sr <= sr;
        endcase
      end else if (shift_en && eff_op != OP_BYPASS) begin
        sr <= {tdi, sr[TRIG_WIDTH-1:1]};
      end
    end
  end

  assign tdo = (eff_op != OP_BYPASS) ? sr[0] : bypass_reg;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign wr_en[g]   = udr_en && eff_op == OP_WRITE && ch == CH_BITS'(g);
    assign mode_en[g] = udr_en && eff_op == OP_MODE  && ch == CH_BITS'(g);

    vjtag_trig_chan #(
      .TRIG_WIDTH (TRIG_WIDTH),
      .PULSE_LEN  (PULSE_LEN)
    ) u_chan (
      .tck         (tck),
      .rst_n       (rst_n),
      .wr_en       (wr_en[g]),
      .mode_en     (mode_en[g]),
      .mode_bit    (sr[0]),
      .wr_data     (sr),
      .value       (ch_value[g]),
      .mode        (ch_mode[g]),
      .trig_out    (trig_out[g*TRIG_WIDTH +: TRIG_WIDTH]),
      .trig_strobe (trig_strobe[g])
    );
  end

endmodule

// File: tb/tb_vjtag_trig_bank.sv
// Bench for vjtag_trig_bank: a 4-channel and a 3-channel instance share one stimulus stream.
module tb_vjtag_trig_bank;
  import vjtag_trig_pkg::*;

  localparam int W = 32;
  localparam int L = 8;

  // clock / reset
  logic tck = 1'b0;
  logic rst_n = 1'b0;
  always #5 tck = ~tck;

  logic [3:0]   ir = '0;
  logic         tdi = 1'b0, cdr = 1'b0, sdr = 1'b0, udr = 1'b0;
  logic [127:0] status4 = '0;
  logic         tdo4, tdo3;
  logic [127:0] trig4;
  logic [95:0]  trig3;
  logic [3:0]   stb4;
  logic [2:0]   stb3;

  vjtag_trig_bank #(.TRIG_WIDTH(W), .NUM_CH(4), .CH_BITS(2), .PULSE_LEN(L)) dut4 (
    .tck(tck), .rst_n(rst_n), .ir_in(ir), .tdi(tdi), .tdo(tdo4),
    .cdr(cdr), .sdr(sdr), .udr(udr), .status_in(status4),
    .trig_out(trig4), .trig_strobe(stb4));

  vjtag_trig_bank #(.TRIG_WIDTH(W), .NUM_CH(3), .CH_BITS(2), .PULSE_LEN(L)) dut3 (
    .tck(tck), .rst_n(rst_n), .ir_in(ir), .tdi(tdi), .tdo(tdo3),
    .cdr(cdr), .sdr(sdr), .udr(udr), .status_in(status4[95:0]),
    .trig_out(trig3), .trig_strobe(stb3));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // reference model: per-instance state, pulse tracked as an absolute end cycle
  logic [W-1:0] m_sr  [2];
  logic         m_byp [2];
  logic [W-1:0] m_val [2][4];
  logic         m_mode[2][4];
  int           m_end [2][4];
  logic [3:0]   m_stb [2];
  int           t = 0;

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [1:0] eff_op(input int d);
    return (int'(ir[1:0]) < nch(d)) ? ir[3:2] : OP_BYPASS;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sr[d] = '0; m_byp[d] = 1'b0; m_stb[d] = '0;
      for (int k = 0; k < 4; k++) begin
        m_val[d][k] = '0; m_mode[d][k] = 1'b0; m_end[d][k] = -1;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [1:0] op;
      int c;
      op = eff_op(d);
      c  = int'(ir[1:0]);
      m_stb[d] = '0;
      if (cdr) begin
        if (op == OP_WRITE)  m_sr[d] = m_val[d][c];
        if (op == OP_STATUS) m_sr[d] = status4[c*W +: W];
        if (op == OP_MODE)   m_sr[d] = {31'b0, m_mode[d][c]};
      end else if (sdr) begin
        if (op != OP_BYPASS) m_sr[d] = {tdi, m_sr[d][W-1:1]};
      end else if (udr) begin
        if (op == OP_WRITE) begin
          m_val[d][c] = m_sr[d];
          m_stb[d][c] = 1'b1;
          if (m_mode[d][c]) m_end[d][c] = t + L - 1;
        end
        if (op == OP_MODE) begin
          if (!m_mode[d][c] && m_sr[d][0]) m_end[d][c] = -1;
          m_mode[d][c] = m_sr[d][0];
        end
      end
      m_byp[d] = tdi;
    end
  endtask

  function automatic logic [W-1:0] exp_trig(input int d, input int k);
    if (!m_mode[d][k]) return m_val[d][k];
    return (t <= m_end[d][k]) ? m_val[d][k] : '0;
  endfunction

  // scoreboard
  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at t=%0d: got %h expected %h", name, idx, t, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) chk("trig4", k, trig4[k*W +: W], exp_trig(0, k));
    for (int k = 0; k < 3; k++) chk("trig3", k, trig3[k*W +: W], exp_trig(1, k));
    chk("strobe4", 0, {28'b0, stb4}, {28'b0, m_stb[0]});
    chk("strobe3", 0, {29'b0, stb3}, {28'b0, m_stb[1]});
    chk("tdo4", 0, {31'b0, tdo4}, {31'b0, (eff_op(0) != OP_BYPASS) ? m_sr[0][0] : m_byp[0]});
    chk("tdo3", 0, {31'b0, tdo3}, {31'b0, (eff_op(1) != OP_BYPASS) ? m_sr[1][0] : m_byp[1]});
  endtask

  // drivers
  task automatic cyc(input logic c, input logic s, input logic u, input logic d);
    cdr = c; sdr = s; udr = u; tdi = d;
    @(posedge tck);
    t++;
    if (rst_n) model_step(); else model_reset();
    @(negedge tck);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic scan(input logic [1:0] op, input logic [1:0] c, input logic [W-1:0] data,
                      input logic do_udr, output logic [W-1:0] cap);
    ir = {op, c};
    cyc(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    cap[0] = tdo4;
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, 1'b1, 1'b0, data[i]);
      if (i < W - 1) cap[i+1] = tdo4;
    end
    if (do_udr) cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [1:0]   ch;
    logic [W-1:0] data;
    logic [3:0]   exp_stb4;
    logic [2:0]   exp_stb3;
    logic [W-1:0] exp_trig4;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] cap;
    int n_old, n_new;

    vecs[0] = '{OP_WRITE,  2'd2, 32'hDEADBEEF, 4'b0100, 3'b100, 32'hDEADBEEF};
    vecs[1] = '{OP_WRITE,  2'd0, 32'h12345678, 4'b0001, 3'b001, 32'h12345678};
    vecs[2] = '{OP_STATUS, 2'd1, 32'hFFFFFFFF, 4'b0000, 3'b000, 32'h00000000};
    vecs[3] = '{OP_BYPASS, 2'd2, 32'h00000000, 4'b0000, 3'b000, 32'hDEADBEEF};
    vecs[4] = '{OP_WRITE,  2'd3, 32'hCAFEF00D, 4'b1000, 3'b000, 32'hCAFEF00D};
    vecs[5] = '{OP_MODE,   2'd3, 32'h00000000, 4'b0000, 3'b000, 32'hCAFEF00D};

    // reset held with random tdi
    model_reset();
    repeat (4) idle();
    rst_n = 1'b1;
    idle();

    // table-driven commits
    for (int v = 0; v < 6; v++) begin
      scan(vecs[v].op, vecs[v].ch, vecs[v].data, 1'b0, cap);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("vec_stb4", v, {28'b0, stb4}, {28'b0, vecs[v].exp_stb4});
      chk("vec_stb3", v, {29'b0, stb3}, {29'b0, vecs[v].exp_stb3});
      chk("vec_trig4", v, trig4[int'(vecs[v].ch)*W +: W], vecs[v].exp_trig4);
      idle();
      chk("vec_stb4_off", v, {28'b0, stb4}, 32'h0);
    end

    // readback of channel 2, LSB first
    exp_q.push_back(32'hDEADBEEF);
    scan(OP_WRITE, 2'd2, 32'hDEADBEEF, 1'b0, cap);
    chk("readback_ch2", 2, cap, exp_q.pop_front());

    // status capture, then update must not touch any channel
    status4[3*W +: W] = 32'h000000A5;
    exp_q.push_back(32'h000000A5);
    scan(OP_STATUS, 2'd3, 32'h0F0F0F0F, 1'b1, cap);
    chk("status_ch3", 3, cap, exp_q.pop_front());
    chk("status_trig3", 3, trig4[3*W +: W], 32'hCAFEF00D);

    // pulse mode: 8-cycle pulse, then re-write at pulse cycle 5
    scan(OP_MODE, 2'd1, 32'h1, 1'b1, cap);
    scan(OP_WRITE, 2'd1, 32'h5, 1'b0, cap);
    n_new = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    if (trig4[W +: W] == 32'h5) n_new++;
    for (int i = 0; i < 15; i++) begin
      idle();
      if (trig4[W +: W] == 32'h5) n_new++;
    end
    chk("pulse_len", 1, 32'(n_new), 32'(L));
    scan(OP_WRITE, 2'd1, 32'h9, 1'b0, cap);
    n_old = 0; n_new = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    if (trig4[W +: W] == 32'h9) n_old++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0); if (trig4[W +: W] == 32'h9) n_old++;
    cyc(1'b0, 1'b1, 1'b0, 1'b1); if (trig4[W +: W] == 32'h9) n_old++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0); if (trig4[W +: W] == 32'h9) n_old++;
    cyc(1'b0, 1'b1, 1'b0, 1'b1); if (trig4[W +: W] == 32'h9) n_old++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    if (trig4[W +: W] == 32'hA0000000) n_new++;
    for (int i = 0; i < 15; i++) begin
      idle();
      if (trig4[W +: W] == 32'hA0000000) n_new++;
    end
    chk("pulse_old_len", 1, 32'(n_old), 32'd5);
    chk("pulse_new_len", 1, 32'(n_new), 32'(L));

    // pulse -> level shows held value; level -> pulse goes quiet
    scan(OP_MODE, 2'd1, 32'h0, 1'b1, cap);
    chk("to_level", 1, trig4[W +: W], 32'hA0000000);
    scan(OP_MODE, 2'd1, 32'h1, 1'b1, cap);
    chk("to_pulse", 1, trig4[W +: W], 32'h0);

    // out-of-range channel on the 3-channel instance acts as bypass
    ir = {OP_WRITE, 2'd3};
    for (int i = 0; i < 8; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      cyc(1'b0, 1'b1, 1'b0, b);
      chk("bypass_tdo3", i, {31'b0, tdo3}, {31'b0, b});
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bypass_stb3", 0, {29'b0, stb3}, 32'h0);

    // async reset during an active pulse
    scan(OP_WRITE, 2'd1, 32'h77, 1'b0, cap);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("arst_pulse", 1, trig4[W +: W], 32'h0);
    repeat (2) idle();
    rst_n = 1'b1;
    idle();

    // async reset mid-shift discards the partial word
    ir = {OP_WRITE, 2'd0};
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    idle();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("arst_shift", 0, trig4[0 +: W], 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [2:0] r;
      ir = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        status4 = {$urandom(), $urandom(), $urandom(), $urandom()};
      r = 3'($urandom_range(0, 7));
      if (r[2:1] == 2'b00) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      else if (r == 3'd2) cyc(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      else if (r == 3'd3) cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      else if (r == 3'd4) idle();
      else cyc(r[0], r[1], 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
